// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared destination codes and dispatch entry layout
package top_pkg;

    localparam logic MEMORY_OUT = 1'b0;
    localparam logic ALU_OUT    = 1'b1;

    localparam int ENTRY_DATA_W = 20;

    typedef struct packed {
        logic                    sel;
        logic [ENTRY_DATA_W-1:0] data;
    } dispatch_entry_t;

endpackage

// File: rtl/top_dispatch_fifo.sv
// rtl/top_dispatch_fifo.sv - generic synchronous FIFO with registered occupancy
module top_dispatch_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push is refused when full even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/top_dispatch.sv
// rtl/top_dispatch.sv - in-order router of buffered words to memory or ALU path
module top_dispatch
    import top_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 20,
    parameter int ALU_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              alu_valid,
    output logic [ALU_W-1:0]  alu_data,
    input  logic              alu_ready,
    output logic [CNT_W-1:0]  mem_cnt,
    output logic [CNT_W-1:0]  alu_cnt,
    output logic              trunc_err
);

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              mem_pop;
    logic              alu_pop;
    logic [DATA_W:0]   wr_entry;
    logic [DATA_W:0]   head_entry;
    logic              head_sel;
    logic [DATA_W-1:0] head_data;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign wr_entry = {in_sel, in_data};

    top_dispatch_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(wr_entry),
        .full (full),
        .empty(empty),
        .head (head_entry)
    );

    assign head_sel  = head_entry[DATA_W];
    assign head_data = head_entry[DATA_W-1:0];

    // The head alone decides the destination, so a stalled head blocks both paths.
    assign mem_valid = !rst && !empty && (head_sel == MEMORY_OUT);
    assign alu_valid = !rst && !empty && (head_sel == ALU_OUT);
    assign mem_data  = head_data;
    assign alu_data  = head_data[ALU_W-1:0];

    assign mem_pop = mem_valid && mem_ready;
    assign alu_pop = alu_valid && alu_ready;
    assign pop     = mem_pop || alu_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt   <= '0;
            alu_cnt   <= '0;
            trunc_err <= 1'b0;
        end else begin
            if (mem_pop && (mem_cnt != '1)) mem_cnt <= mem_cnt + 1'b1;
            if (alu_pop && (alu_cnt != '1)) alu_cnt <= alu_cnt + 1'b1;
            if (push && (in_sel == ALU_OUT) && (|in_data[DATA_W-1:ALU_W]))
                trunc_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_top_dispatch.sv
// tb/tb_top_dispatch.sv - directed self-checking bench for top_dispatch
module tb_top_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sel;
    logic [19:0] in_data;
    logic        in_ready;
    logic        mem_valid;
    logic [19:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic [7:0]  mem_cnt;
    logic [7:0]  alu_cnt;
    logic        trunc_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    top_dispatch #(
        .DEPTH (4),
        .DATA_W(20),
        .ALU_W (16),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_valid(mem_valid),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .alu_valid(alu_valid),
        .alu_data (alu_data),
        .alu_ready(alu_ready),
        .mem_cnt  (mem_cnt),
        .alu_cnt  (alu_cnt),
        .trunc_err(trunc_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [19:0] fill_data [5];
    logic        fill_sel  [5];
    int          bubbles;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        mem_ready = 1'b0; alu_ready = 1'b0;
        #1;
        check("in_ready_during_rst", in_ready, 0);
        check("mem_valid_during_rst", mem_valid, 0);
        tick(); tick();
        check("rst_mem_cnt", mem_cnt, 0);
        check("rst_alu_cnt", alu_cnt, 0);
        check("rst_trunc", trunc_err, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        check("alu_valid_after_rst", alu_valid, 0);

        // single memory word
        in_valid = 1'b1; in_sel = 1'b0; in_data = 20'hABCDE; mem_ready = 1'b1;
        #1;
        check("no_comb_path", mem_valid, 0);
        tick();
        in_valid = 1'b0;
        check("t1_mem_valid", mem_valid, 1);
        check("t1_mem_data", mem_data, 20'hABCDE);
        check("t1_alu_valid", alu_valid, 0);
        tick();
        check("t1_drained", mem_valid, 0);
        check("t1_mem_cnt", mem_cnt, 1);
        check("t1_alu_cnt", alu_cnt, 0);
        check("t1_trunc", trunc_err, 0);

        // truncating ALU word, then a clean one
        in_valid = 1'b1; in_sel = 1'b1; in_data = 20'h31234; alu_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("t2_alu_valid", alu_valid, 1);
        check("t2_alu_data", alu_data, 16'h1234);
        check("t2_mem_valid", mem_valid, 0);
        check("t2_trunc_set", trunc_err, 1);
        alu_ready = 1'b1;
        tick();
        check("t2_alu_cnt", alu_cnt, 1);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 20'h00001;
        tick();
        in_valid = 1'b0;
        check("t2_alu_data2", alu_data, 16'h0001);
        check("t2_trunc_sticky", trunc_err, 1);
        tick();
        check("t2_alu_cnt2", alu_cnt, 2);
        check("t2_empty", alu_valid, 0);

        // fill past capacity with both readies low
        mem_ready = 1'b0; alu_ready = 1'b0;
        fill_data[0] = 20'h00010; fill_sel[0] = 1'b0;
        fill_data[1] = 20'h00011; fill_sel[1] = 1'b1;
        fill_data[2] = 20'h00012; fill_sel[2] = 1'b0;
        fill_data[3] = 20'h00013; fill_sel[3] = 1'b1;
        fill_data[4] = 20'h00014; fill_sel[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sel = fill_sel[i]; in_data = fill_data[i];
            #1;
            check($sformatf("t3_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        check("t3_full", in_ready, 0);
        mem_ready = 1'b1; alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (fill_sel[i]) begin
                check($sformatf("t3_alu_valid_%0d", i), alu_valid, 1);
                check($sformatf("t3_alu_data_%0d", i), alu_data, {12'h0, fill_data[i][15:0]});
            end else begin
                check($sformatf("t3_mem_valid_%0d", i), mem_valid, 1);
                check($sformatf("t3_mem_data_%0d", i), mem_data, fill_data[i]);
            end
            tick();
            if (i == 0) check("t3_ready_after_pop", in_ready, 1);
        end
        check("t3_drained_mem", mem_valid, 0);
        check("t3_drained_alu", alu_valid, 0);
        check("t3_mem_cnt", mem_cnt, 3);
        check("t3_alu_cnt", alu_cnt, 4);

        // stalled ALU head blocks a later memory word
        mem_ready = 1'b1; alu_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 20'h00020;
        tick();
        in_sel = 1'b1; in_data = 20'h00021;
        tick();
        in_sel = 1'b0; in_data = 20'h00022;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("t4_blocked_mem", mem_valid, 0);
        check("t4_head_alu", alu_valid, 1);
        check("t4_head_data", alu_data, 16'h0021);
        alu_ready = 1'b1;
        tick();
        check("t4_next_mem", mem_valid, 1);
        check("t4_next_data", mem_data, 20'h00022);
        tick();
        check("t4_drained", mem_valid, 0);
        check("t4_mem_cnt", mem_cnt, 5);
        check("t4_alu_cnt", alu_cnt, 5);

        // sustained memory stream to saturation
        mem_ready = 1'b1; alu_ready = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = 20'(i);
            tick();
            if (!(mem_valid && in_ready && mem_data == 20'(i))) bubbles++;
        end
        in_valid = 1'b0;
        tick();
        check("t5_no_bubbles", bubbles, 0);
        check("t5_mem_cnt_sat", mem_cnt, 255);
        check("t5_alu_cnt", alu_cnt, 5);
        check("t5_empty", mem_valid, 0);

        // reset with entries buffered
        mem_ready = 1'b0; alu_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 20'hF0030;
        tick();
        in_sel = 1'b0; in_data = 20'h00031;
        tick();
        in_sel = 1'b1; in_data = 20'h00032;
        tick();
        in_valid = 1'b0;
        check("t6_trunc_pre", trunc_err, 1);
        check("t6_head_alu_pre", alu_valid, 1);
        rst = 1'b1; mem_ready = 1'b1; alu_ready = 1'b1;
        #1;
        check("t6_in_ready_rst", in_ready, 0);
        check("t6_alu_valid_rst", alu_valid, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_mem_valid", mem_valid, 0);
        check("t6_alu_valid", alu_valid, 0);
        check("t6_mem_cnt", mem_cnt, 0);
        check("t6_alu_cnt", alu_cnt, 0);
        check("t6_trunc", trunc_err, 0);
        check("t6_in_ready", in_ready, 1);
        tick();
        check("t6_still_empty", mem_valid | alu_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
